// File: rtl/network_argmax.sv
// rtl/network_argmax.sv - streaming argmax over groups of N signed values
// Running max/index per vector; the last element resolves straight into a one-deep output buffer.
module network_argmax #(
  parameter int T  = 16,
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [T-1:0]  data_in,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [IW-1:0] data_out_idx,
  output logic [T-1:0]  data_out_max
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [IW-1:0] cnt_q, cnt_d;
  logic [T-1:0]  run_max_q, run_max_d;
  logic [IW-1:0] run_idx_q, run_idx_d;
  logic          m_valid_q, m_valid_d;
  logic [T-1:0]  out_max_q, out_max_d;
  logic [IW-1:0] out_idx_q, out_idx_d;

  logic          is_last;
  logic          in_fire;
  logic          take_new;
  logic [T-1:0]  cand_max;
  logic [IW-1:0] cand_idx;

  // Only the final element can stall: it needs the output buffer free or draining.
  assign is_last  = (cnt_q == LAST_IDX);
  assign s_ready  = !(is_last && m_valid_q && !m_ready);
  assign in_fire  = s_valid && s_ready;

  // Strict greater-than keeps the lowest index on ties.
  assign take_new = (cnt_q == '0) || ($signed(data_in) > $signed(run_max_q));
  assign cand_max = take_new ? data_in : run_max_q;
  assign cand_idx = take_new ? cnt_q : run_idx_q;

  always_comb begin
    cnt_d     = cnt_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    m_valid_d = m_valid_q;
    out_max_d = out_max_q;
    out_idx_d = out_idx_q;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (in_fire) begin
      if (is_last) begin
        cnt_d     = '0;
        out_max_d = cand_max;
        out_idx_d = cand_idx;
        m_valid_d = 1'b1;
      end else begin
        cnt_d     = cnt_q + IW'(1);
        run_max_d = cand_max;
        run_idx_d = cand_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      m_valid_q <= 1'b0;
      out_max_q <= '0;
      out_idx_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      m_valid_q <= m_valid_d;
      out_max_q <= out_max_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign m_valid      = m_valid_q;
  assign data_out_max = out_max_q;
  assign data_out_idx = out_idx_q;

endmodule

// File: tb/tb_network_argmax.sv
// tb/tb_network_argmax.sv - scoreboard bench for network_argmax
// Driver pushes reference argmax results; a negedge monitor pops them on every output handshake.
module tb_network_argmax;

  localparam int T  = 16;
  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [T-1:0]  data_in = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [IW-1:0] data_out_idx;
  logic [T-1:0]  data_out_max;

  network_argmax #(.T(T), .N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .data_in      (data_in),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .data_out_idx (data_out_idx),
    .data_out_max (data_out_max)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int n_popped = 0;
  int rmode    = 0;  // 0: m_ready=1, 1: random, 2: m_ready=0

  logic [T-1:0]      vec [N];
  logic [IW+T-1:0]   exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW+T-1:0] ref_argmax();
    logic [IW-1:0] bi;
    logic [T-1:0]  bm;
    bi = '0;
    bm = vec[0];
    for (int i = 1; i < N; i++) begin
      if ($signed(vec[i]) > $signed(bm)) begin
        bm = vec[i];
        bi = IW'(i);
      end
    end
    return {bi, bm};
  endfunction

  always @(posedge clk) begin
    #2;
    case (rmode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(1));
      default: m_ready = 1'b0;
    endcase
  end

  logic          held = 1'b0;
  logic [IW-1:0] held_idx;
  logic [T-1:0]  held_max;
  logic [IW+T-1:0] exp_v;

  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", {31'b0, m_valid}, 32'd1);
        check("hold_idx", {28'b0, data_out_idx}, {28'b0, held_idx});
        check("hold_max", {16'b0, data_out_max}, {16'b0, held_max});
      end
      if (m_valid && m_ready) begin
        held = 1'b0;
        n_popped++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", {28'b0, data_out_idx}, 32'hFFFF_FFFF);
        end else begin
          exp_v = exp_q.pop_front();
          check("result_idx", {28'b0, data_out_idx}, {28'b0, exp_v[IW+T-1:T]});
          check("result_max", {16'b0, data_out_max}, {16'b0, exp_v[T-1:0]});
        end
      end else if (m_valid) begin
        held = 1'b1;
        held_idx = data_out_idx;
        held_max = data_out_max;
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic drive_beat(input logic [T-1:0] v, input bit gaps, output int waits);
    bit acc;
    if (gaps) begin
      while ($urandom_range(3) == 0) begin
        s_valid = 1'b0;
        data_in = T'($urandom);
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b1;
    data_in = v;
    waits = 0;
    forever begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      if (acc) break;
      waits++;
      if (waits >= 1000) begin
        n_checks++;
        n_fail++;
        $display("FAIL beat_timeout: s_ready low for %0d cycles, expected accept", waits);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic send_vec(input bit gaps);
    int w;
    exp_q.push_back(ref_argmax());
    n_pushed++;
    for (int i = 0; i < N; i++) drive_beat(vec[i], gaps, w);
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_s_ready", {31'b0, s_ready}, 32'd1);
    check("rst_idx", {28'b0, data_out_idx}, 32'd0);
    check("rst_max", {16'b0, data_out_max}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ascending, with latency check around the last beat
    for (int i = 0; i < N; i++) vec[i] = T'(i);
    exp_q.push_back(ref_argmax());
    n_pushed++;
    for (int i = 0; i < N - 1; i++) drive_beat(vec[i], 1'b0, w);
    check("asc_pre_valid", {31'b0, m_valid}, 32'd0);
    drive_beat(vec[N-1], 1'b0, w);
    check("asc_lat_valid", {31'b0, m_valid}, 32'd1);
    check("asc_idx", {28'b0, data_out_idx}, 32'd15);
    check("asc_max", {16'b0, data_out_max}, 32'h000F);

    // ties then descending
    for (int i = 0; i < N; i++) vec[i] = 16'd5;
    send_vec(1'b0);
    for (int i = 0; i < N; i++) vec[i] = T'(15 - i);
    send_vec(1'b0);

    // signed compare
    for (int i = 0; i < N; i++) vec[i] = 16'h8000;
    vec[7] = 16'hFFFF;
    send_vec(1'b0);
    for (int i = 0; i < N; i++) vec[i] = 16'h8000;
    send_vec(1'b0);
    drain();

    // backpressure: A held while B's leading elements stream in
    rmode = 2;
    m_ready = 1'b0;
    for (int i = 0; i < N; i++) vec[i] = T'(i + 1);
    send_vec(1'b0);
    repeat (14) begin @(posedge clk); #1; end
    for (int i = 0; i < N; i++) vec[i] = T'($urandom_range(50));
    vec[3] = 16'd1000;
    exp_q.push_back(ref_argmax());
    n_pushed++;
    for (int i = 0; i < N - 1; i++) begin
      drive_beat(vec[i], 1'b0, w);
      check("bp_lead_accept", w, 32'd0);
    end
    s_valid = 1'b1;
    data_in = vec[N-1];
    repeat (3) begin
      @(negedge clk);
      check("bp_stall_s_ready", {31'b0, s_ready}, 32'd0);
      check("bp_a_idx", {28'b0, data_out_idx}, 32'd15);
      check("bp_a_max", {16'b0, data_out_max}, 32'h0010);
      @(posedge clk); #1;
    end
    rmode = 0;
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_release_s_ready", {31'b0, s_ready}, 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    check("bp_swap_valid", {31'b0, m_valid}, 32'd1);
    check("bp_b_idx", {28'b0, data_out_idx}, 32'd3);
    check("bp_b_max", {16'b0, data_out_max}, 32'd1000);
    drain();

    // reset mid-vector
    for (int i = 0; i < 5; i++) drive_beat(16'h7FFF, 1'b0, w);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_m_valid", {31'b0, m_valid}, 32'd0);
    check("midrst_s_ready", {31'b0, s_ready}, 32'd1);
    for (int i = 0; i < N; i++) vec[i] = T'($urandom_range(255));
    vec[9] = 16'h0100;
    send_vec(1'b0);
    drain();

    // random soak
    rmode = 1;
    for (int v = 0; v < 2500; v++) begin
      case ($urandom_range(2))
        0:       for (int i = 0; i < N; i++) vec[i] = T'($urandom);
        1:       for (int i = 0; i < N; i++) vec[i] = T'($urandom_range(3));
        default: for (int i = 0; i < N; i++) vec[i] = T'($urandom_range(4)) - 16'd2;
      endcase
      send_vec(1'b1);
    end
    rmode = 0;
    drain();
    repeat (4) begin @(posedge clk); #1; end
    check("result_count", n_popped, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
